risc_ctrl: RTL

RISC_CTRL -- requirements
Module: risc_ctrl

---
 rtl/risc_ctrl_pkg.sv | 26 ++
 rtl/risc_ctrl_if.sv | 22 ++
 rtl/risc_step_fsm.sv | 75 +++++++
 rtl/risc_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/risc_ctrl_pkg.sv
// Shared constants for the RISC control block: control-word bit positions,
// parameter limits and the single-step state encoding.
package risc_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NIRQ_MAX    = 8;
  localparam int unsigned STEP_W_MAX  = 8;

  localparam int unsigned BIT_GO      = 0;
  localparam int unsigned BIT_CPUINT  = 1;
  localparam int unsigned BIT_FORCE0  = 2;
  localparam int unsigned BIT_SSTEP   = 3;
  localparam int unsigned BIT_SGO     = 4;
  localparam int unsigned BIT_SSTOP   = 5;
  localparam int unsigned PEND_LSB    = 6;
  localparam int unsigned MASK_LSB    = 14;
  localparam int unsigned BIT_BUS_HOG = 22;
  localparam int unsigned CNT_LSB     = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } step_state_e;

endpackage

// File: rtl/risc_ctrl_if.sv
// Control-register write / status-read bus between the host and risc_ctrl.
interface risc_ctrl_if
  import risc_ctrl_pkg::*;
();

  logic              ctrl_wr;
  logic [DATA_W-1:0] ctrl_wdata;
  logic              stat_rd;
  logic [DATA_W-1:0] stat_rdata;
  logic              stat_oe;

  modport master (
    output ctrl_wr, ctrl_wdata, stat_rd,
    input  stat_rdata, stat_oe
  );

  modport slave (
    input  ctrl_wr, ctrl_wdata, stat_rd,
    output stat_rdata, stat_oe
  );

endinterface

// File: rtl/risc_step_fsm.sv
// Single-step controller: runs the CPU for a programmed number of retired
// instructions, then parks in STOPPED until the next step-go.
module risc_step_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sstep_n,
  input  logic              sgo_wr,
  input  logic [STEP_W-1:0] load_cnt,
  input  logic              instr_done,
  output logic              single_go,
  output logic              sstop,
  output logic [STEP_W-1:0] cnt
);

  step_state_e       state_q, state_n;
  logic [STEP_W-1:0] cnt_q, cnt_n;
  logic [STEP_W-1:0] load_eff;
  logic              single_go_q, sstop_q;

  // A programmed count of zero still executes one instruction.
  assign load_eff = (load_cnt == '0) ? STEP_W'(1) : load_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      single_go_q <= 1'b0;
      sstop_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      single_go_q <= (state_n == ST_RUN);
      sstop_q     <= (state_n == ST_STOPPED);
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sstep_n && sgo_wr) begin
          state_n = ST_RUN;
          cnt_n   = load_eff;
        end
      end
      ST_RUN: begin
        if (!sstep_n) begin
          state_n = ST_IDLE;
        end else if (instr_done) begin
          cnt_n = cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) state_n = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        if (!sstep_n) begin
          state_n = ST_IDLE;
        end else if (sgo_wr) begin
          state_n = ST_RUN;
          cnt_n   = load_eff;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign single_go = single_go_q;
  assign sstop     = sstop_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/risc_ctrl.sv
// RISC control/status register block: run control, host interrupt,
// interrupt pending/mask logic and single-step sequencing.
module risc_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int unsigned NIRQ   = 5,
  parameter int unsigned STEP_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  risc_ctrl_if.slave      bus,
  input  logic            instr_done,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            halt_req,
  output logic            go,
  output logic            single_step,
  output logic            single_go,
  output logic            bus_hog,
  output logic            cpu_int,
  output logic            irq_out,
  output logic [NIRQ-1:0] irq_pend
);

  if (NIRQ < 1 || NIRQ > NIRQ_MAX) begin : g_bad_nirq
    $error("risc_ctrl: NIRQ out of range");
  end
  if (STEP_W < 1 || STEP_W > STEP_W_MAX) begin : g_bad_step_w
    $error("risc_ctrl: STEP_W out of range");
  end

  logic              go_q, sstep_q, bus_hog_q, cpu_int_q, irq_out_q;
  logic [NIRQ-1:0]   mask_q, pend_q, irq_prev_q;
  logic [DATA_W-1:0] stat_rdata_q;
  logic              stat_oe_q;

  logic              go_n, sstep_n, bus_hog_n;
  logic [NIRQ-1:0]   mask_n, pend_n, pend_set, pend_clr;
  logic [DATA_W-1:0] stat_word;
  logic              sgo_wr, sstop;
  logic [STEP_W-1:0] step_cnt;
  logic              unused_wdata;

  assign unused_wdata = ^bus.ctrl_wdata;

  // Next-state for the control fields; halt beats a same-cycle GO write.
  always_comb begin
    go_n      = go_q;
    sstep_n   = sstep_q;
    bus_hog_n = bus_hog_q;
    mask_n    = mask_q;
    pend_clr  = '0;
    pend_set  = irq_in & ~irq_prev_q;
    if (bus.ctrl_wr) begin
      go_n      = bus.ctrl_wdata[BIT_GO];
      sstep_n   = bus.ctrl_wdata[BIT_SSTEP];
      bus_hog_n = bus.ctrl_wdata[BIT_BUS_HOG];
      mask_n    = bus.ctrl_wdata[MASK_LSB +: NIRQ];
      pend_clr  = bus.ctrl_wdata[PEND_LSB +: NIRQ];
      pend_set[0] = pend_set[0] | bus.ctrl_wdata[BIT_FORCE0];
    end
    if (halt_req) go_n = 1'b0;
    pend_n = (pend_q & ~pend_clr) | pend_set;
  end

  assign sgo_wr = bus.ctrl_wr & bus.ctrl_wdata[BIT_SGO];

  // Status word reflects state before any same-cycle write.
  always_comb begin
    stat_word                      = '0;
    stat_word[BIT_GO]              = go_q;
    stat_word[BIT_SSTEP]           = sstep_q;
    stat_word[BIT_SSTOP]           = sstop;
    stat_word[PEND_LSB +: NIRQ]    = pend_q;
    stat_word[MASK_LSB +: NIRQ]    = mask_q;
    stat_word[BIT_BUS_HOG]         = bus_hog_q;
    stat_word[CNT_LSB +: STEP_W]   = step_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q         <= 1'b0;
      sstep_q      <= 1'b0;
      bus_hog_q    <= 1'b0;
      cpu_int_q    <= 1'b0;
      irq_out_q    <= 1'b0;
      mask_q       <= '0;
      pend_q       <= '0;
      irq_prev_q   <= '0;
      stat_rdata_q <= '0;
      stat_oe_q    <= 1'b0;
    end else begin
      go_q         <= go_n;
      sstep_q      <= sstep_n;
      bus_hog_q    <= bus_hog_n;
      cpu_int_q    <= bus.ctrl_wr & bus.ctrl_wdata[BIT_CPUINT];
      irq_out_q    <= |(pend_n & mask_n);
      mask_q       <= mask_n;
      pend_q       <= pend_n;
      irq_prev_q   <= irq_in;
      stat_rdata_q <= bus.stat_rd ? stat_word : '0;
      stat_oe_q    <= bus.stat_rd;
    end
  end

  risc_step_fsm #(.STEP_W(STEP_W)) u_step (
    .clk        (clk),
    .reset      (reset),
    .sstep_n    (sstep_n),
    .sgo_wr     (sgo_wr),
    .load_cnt   (bus.ctrl_wdata[CNT_LSB +: STEP_W]),
    .instr_done (instr_done),
    .single_go  (single_go),
    .sstop      (sstop),
    .cnt        (step_cnt)
  );

  assign go             = go_q;
  assign single_step    = sstep_q;
  assign bus_hog        = bus_hog_q;
  assign cpu_int        = cpu_int_q;
  assign irq_out        = irq_out_q;
  assign irq_pend       = pend_q;
  assign bus.stat_rdata = stat_rdata_q;
  assign bus.stat_oe    = stat_oe_q;

endmodule
